// File: rtl/foo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foo_pkg
// Purpose  : Shared FSM encoding and wrap-around priority search for foo_rr_arbiter.
// Revision : 1.0
// ============================================================================
package foo_pkg;

  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n rather than at a power of 2.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if ((i < n) && !res.found && req[k[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = k[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/foo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : foo_rr_pick
// Purpose  : Combinational wrap-around priority search of req starting at ptr.
// Revision : 1.0
// ============================================================================
module foo_rr_pick
  import foo_pkg::*;
#(
  parameter  int N     = 5,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  rr_pick_t w_pick;
  logic     w_unused_idx;

  assign w_pick       = rr_pick(RR_MAX_N'(req_i), RR_IDX_W'(ptr_i), N);
  assign found_o      = w_pick.found;
  assign idx_o        = w_pick.idx[IDX_W-1:0];
  assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/foo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : foo_rr_arbiter
// Purpose  : Round-robin arbiter with bounded hold time sharing one foo_intf sink.
// Revision : 1.0
// ============================================================================
module foo_rr_arbiter
  import foo_pkg::*;
#(
  parameter  int N        = 5,
  parameter  int HOLD_MAX = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  input  logic [N-1:0]     a_in,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             a_out,
  output logic             timeout
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             timeout_q, timeout_d;

  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_drop;
  logic             w_expire;

  foo_rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (w_found),
    .idx_o   (w_pick_idx)
  );

  assign w_drop   = !req[idx_q] || done[idx_q];
  assign w_expire = (hold_q == CNT_W'(HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      // The dead cycle also arbitrates, so back-to-back grants are one cycle apart.
      IDLE, RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        if (w_found) begin
          state_d = GRANT;
          gnt_d   = N'(1) << w_pick_idx;
          valid_d = 1'b1;
          idx_d   = w_pick_idx;
          hold_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (w_drop || w_expire) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          idx_d     = '0;
          hold_d    = '0;
          ptr_d     = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
          timeout_d = !w_drop;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;
  assign a_out     = valid_q & a_in[idx_q];

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_valid_any  : assert property (@(posedge clk) disable iff (rst) valid_q == |gnt_q);
  a_idx_match  : assert property (@(posedge clk) disable iff (rst) gnt_q[idx_q] == valid_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_foo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_foo_rr_arbiter
// Purpose  : Self-checking bench for foo_rr_arbiter against a lane-level model.
// Revision : 1.0
// ============================================================================
module tb_foo_rr_arbiter;

  localparam int N        = 5;
  localparam int HOLD_MAX = 4;
  localparam int IDX_W    = 3;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic [N-1:0]     a_in;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             a_out;
  logic             timeout;
  logic [10:0]      obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current holder (-1 = nobody), cycles held, next search start, timeout seen.
  int m_holder = -1;
  int m_cnt    = 0;
  int m_ptr    = 0;
  bit m_to     = 1'b0;

  foo_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .a_in      (a_in),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .a_out     (a_out),
    .timeout   (timeout)
  );

  assign obs = {gnt, gnt_valid, gnt_idx, a_out, timeout};

  always #5 clk = ~clk;

  function automatic logic [10:0] model_out();
    logic [N-1:0]     g;
    logic [IDX_W-1:0] ix;
    logic             v;
    logic             a;
    g = '0; ix = '0; v = 1'b0; a = 1'b0;
    if (m_holder >= 0) begin
      g[m_holder] = 1'b1;
      ix          = IDX_W'(m_holder);
      v           = 1'b1;
      a           = a_in[m_holder];
    end
    return {g, v, ix, a, m_to};
  endfunction

  task automatic step();
    @(posedge clk);
    m_to = 1'b0;
    if (rst) begin
      m_holder = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_holder >= 0) begin
      if (!req[m_holder] || done[m_holder] || m_cnt == HOLD_MAX) begin
        m_to     = req[m_holder] && !done[m_holder];
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
      end else begin
        m_cnt++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_holder < 0 && req[(m_ptr + k) % N]) begin
          m_holder = (m_ptr + k) % N;
          m_cnt    = 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; done = '0; a_in = '0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({gnt, gnt_valid, gnt_idx, timeout} !== 10'b0) begin
      $display("FAIL reset_state: got %b required 0", {gnt, gnt_valid, gnt_idx, timeout});
    end else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    test_reset();
    req = 5'b00100;
    step();
    n_checks++;
    if (gnt !== 5'b00100) $display("FAIL mid_rst_grant: gnt=%b required 00100", gnt);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({gnt, gnt_valid, gnt_idx} !== 9'b0) begin
      $display("FAIL mid_rst_drop: gnt=%b valid=%b idx=%0d required all 0", gnt, gnt_valid, gnt_idx);
    end else n_pass++;
    step();
    n_checks++;
    if (gnt !== 5'b00100 || gnt_idx !== 3'd2) begin
      $display("FAIL mid_rst_regrant: gnt=%b idx=%0d required 00100/2", gnt, gnt_idx);
    end else n_pass++;
  endtask

  task automatic test_single_done();
    test_reset();
    req = 5'b00010;
    step();
    n_checks++;
    if (gnt !== 5'b00010) $display("FAIL single_grant: gnt=%b required 00010", gnt);
    else n_pass++;
    step();
    done = 5'b00010;
    step();
    done = '0;
    n_checks++;
    if (gnt !== 5'b0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL single_release: gnt=%b valid=%b timeout=%b required 0/0/0", gnt, gnt_valid, timeout);
    end else n_pass++;
    // Pointer now 2: lanes 1 and 4 requesting must give lane 4.
    req = 5'b10010;
    step();
    n_checks++;
    if (gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
      $display("FAIL single_ptr: idx=%0d valid=%b required 4/1", gnt_idx, gnt_valid);
    end else n_pass++;
    req = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [IDX_W-1:0] order[$];
    int               exp_order[6] = '{0, 1, 2, 3, 4, 0};
    int               n_to = 0;
    logic             prev = 1'b0;
    test_reset();
    req = 5'b11111;
    for (int c = 0; c < 30; c++) begin
      step();
      n_checks++;
      if (obs !== model_out()) $display("FAIL rr_cycle%0d: got %b required %b", c, obs, model_out());
      else n_pass++;
      if (gnt_valid && !prev) order.push_back(gnt_idx);
      prev = gnt_valid;
      if (timeout) n_to++;
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= order.size()) $display("FAIL rr_order%0d: no grant seen, required %0d", i, exp_order[i]);
      else if (int'(order[i]) != exp_order[i]) $display("FAIL rr_order%0d: got %0d required %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    n_checks++;
    if (n_to != 6) $display("FAIL rr_timeouts: got %0d required 6", n_to);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    test_reset();
    req = 5'b01000;
    step(); step();
    req = 5'b00101;
    step();
    step();
    n_checks++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) $display("FAIL wrap_first: idx=%0d valid=%b required 0/1", gnt_idx, gnt_valid);
    else n_pass++;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (gnt_valid && gnt_idx != 3'd0) seen = 1'b1;
    end
    n_checks++;
    if (!seen || gnt_idx !== 3'd2) $display("FAIL wrap_second: seen=%b idx=%0d required 1/2", seen, gnt_idx);
    else n_pass++;
    req = '0;
    step(); step();
  endtask

  task automatic test_nonholder_done();
    test_reset();
    req = 5'b01000;
    step();
    done = 5'b00001;
    step();
    done = '0;
    n_checks++;
    if (gnt !== 5'b01000 || timeout !== 1'b0) $display("FAIL nh_done_ignored: gnt=%b timeout=%b required 01000/0", gnt, timeout);
    else n_pass++;
    req = '0;
    step();
    n_checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0) $display("FAIL nh_req_drop: valid=%b timeout=%b required 0/0", gnt_valid, timeout);
    else n_pass++;
  endtask

  task automatic test_datapath();
    test_reset();
    a_in = 5'b11111;
    step();
    n_checks++;
    if (a_out !== 1'b0) $display("FAIL dp_idle: a_out=%b required 0", a_out);
    else n_pass++;
    req = 5'b00100;
    step();
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 2; s++) begin
        a_in = (s == 0) ? 5'($urandom) : ~a_in;
        #1;
        n_checks++;
        if (a_out !== a_in[2]) $display("FAIL dp_track: a_out=%b required %b", a_out, a_in[2]);
        else n_pass++;
      end
      step();
    end
    req = '0; a_in = 5'b11111;
    step();
    n_checks++;
    if (a_out !== 1'b0 || gnt !== 5'b0) $display("FAIL dp_release: a_out=%b gnt=%b required 0/0", a_out, gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    test_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = 5'($urandom | $urandom);
      done = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      a_in = 5'($urandom);
      step();
      n_checks++;
      if (obs !== model_out()) $display("FAIL rand_cycle%0d: got %b required %b", c, obs, model_out());
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; done = '0; a_in = '0;
    test_reset();
    test_reset_mid_grant();
    test_single_done();
    test_round_robin();
    test_wrap();
    test_nonholder_done();
    test_datapath();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
